// File: rtl/idu_seq_if.sv
// rtl/idu_seq_if.sv - IFU/immgen/EXU signal bundle for the decode sequencer
// Perf counter outputs exist only when IDU_SEQ_PERF_EN is defined.
interface idu_seq_if #(
  parameter int TYPE_W = 3,
  parameter int XLEN   = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_instr;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   ig_instr;
  logic [TYPE_W-1:0] ig_type;
  logic [XLEN-1:0]   ig_imm;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_instr;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_imm;
  logic [TYPE_W-1:0] out_type;
  logic              out_ebreak;
  logic              halted;
  logic              trap;
  logic [XLEN-1:0]   trap_pc;
`ifdef IDU_SEQ_PERF_EN
  logic [31:0]       perf_decoded;
  logic [31:0]       perf_stall;
  logic [191:0]      perf_type_cnt;
`endif

  modport master (
    input  in_valid, in_instr, in_pc, ig_imm, out_ready,
    output in_ready, ig_instr, ig_type, out_valid, out_instr, out_pc,
           out_imm, out_type, out_ebreak, halted, trap, trap_pc
`ifdef IDU_SEQ_PERF_EN
    , output perf_decoded, perf_stall, perf_type_cnt
`endif
  );

  modport slave (
    output in_valid, in_instr, in_pc, ig_imm, out_ready,
    input  in_ready, ig_instr, ig_type, out_valid, out_instr, out_pc,
           out_imm, out_type, out_ebreak, halted, trap, trap_pc
`ifdef IDU_SEQ_PERF_EN
    , input perf_decoded, perf_stall, perf_type_cnt
`endif
  );
endinterface

// File: rtl/idu_seq.sv
// rtl/idu_seq.sv - decode-stage sequencer: classify, drive immgen, hand bundle to EXU
// Optional perf counters guarded by IDU_SEQ_PERF_EN.
module idu_seq #(
  parameter int TYPE_W = 3,
  parameter int XLEN   = 32
) (
  input logic         clk,
  input logic         rst,
  idu_seq_if.master   bus
);
  localparam logic [TYPE_W-1:0] T_I = TYPE_W'(0);
  localparam logic [TYPE_W-1:0] T_U = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] T_S = TYPE_W'(2);
  localparam logic [TYPE_W-1:0] T_B = TYPE_W'(3);
  localparam logic [TYPE_W-1:0] T_J = TYPE_W'(4);
  localparam logic [TYPE_W-1:0] T_R = TYPE_W'(5);
  localparam logic [XLEN-1:0]   EBREAK = XLEN'(32'h0010_0073);

  typedef enum logic [2:0] {S_IDLE, S_DEC, S_OUT, S_HALT, S_TRAP} state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic [XLEN-1:0]   r_ig_instr;
  logic [TYPE_W-1:0] r_ig_type;
  logic [XLEN-1:0]   r_pc;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_out_instr;
  logic [XLEN-1:0]   r_out_pc;
  logic [XLEN-1:0]   r_out_imm;
  logic [TYPE_W-1:0] r_out_type;
  logic              r_out_ebreak;
  logic              r_halted;
  logic              r_trap;
  logic [XLEN-1:0]   r_trap_pc;

  logic              w_legal;
  logic [TYPE_W-1:0] w_type;

  always_comb begin
    w_legal = 1'b1;
    w_type  = T_R;
    unique case (bus.in_instr[6:0])
      7'b0110111, 7'b0010111:                         w_type = T_U;
      7'b1101111:                                     w_type = T_J;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: w_type = T_I;
      7'b1100011:                                     w_type = T_B;
      7'b0100011:                                     w_type = T_S;
      7'b0110011:                                     w_type = T_R;
      default:                                        w_legal = 1'b0;
    endcase
  end

`ifdef IDU_SEQ_PERF_EN
  logic [31:0] r_perf_decoded;
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_type [6];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b1;
      r_ig_instr   <= '0;
      r_ig_type    <= T_R;
      r_pc         <= '0;
      r_out_valid  <= 1'b0;
      r_out_instr  <= '0;
      r_out_pc     <= '0;
      r_out_imm    <= '0;
      r_out_type   <= '0;
      r_out_ebreak <= 1'b0;
      r_halted     <= 1'b0;
      r_trap       <= 1'b0;
      r_trap_pc    <= '0;
`ifdef IDU_SEQ_PERF_EN
      r_perf_decoded <= '0;
      r_perf_stall   <= '0;
      for (int k = 0; k < 6; k++) r_perf_type[k] <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_in_ready <= 1'b0;
            if (w_legal) begin
              r_ig_instr <= bus.in_instr;
              r_ig_type  <= w_type;
              r_pc       <= bus.in_pc;
              r_state    <= S_DEC;
            end else begin
              r_trap    <= 1'b1;
              r_trap_pc <= bus.in_pc;
              r_state   <= S_TRAP;
            end
          end
        end
        S_DEC: begin
          // ig_imm is combinational from the generator on the instr we drive now
          r_out_instr  <= r_ig_instr;
          r_out_pc     <= r_pc;
          r_out_imm    <= bus.ig_imm;
          r_out_type   <= r_ig_type;
          r_out_ebreak <= (r_ig_instr == EBREAK);
          r_out_valid  <= 1'b1;
          r_ig_instr   <= '0;
          r_ig_type    <= T_R;
          r_state      <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
`ifdef IDU_SEQ_PERF_EN
            r_perf_decoded <= r_perf_decoded + 32'd1;
            for (int k = 0; k < 6; k++)
              if (r_out_type == TYPE_W'(k)) r_perf_type[k] <= r_perf_type[k] + 32'd1;
`endif
            if (r_out_ebreak) begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= S_IDLE;
            end
          end
`ifdef IDU_SEQ_PERF_EN
          else begin
            r_perf_stall <= r_perf_stall + 32'd1;
          end
`endif
        end
        S_HALT, S_TRAP: r_state <= r_state;
        default: begin
          r_in_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.ig_instr   = r_ig_instr;
  assign bus.ig_type    = r_ig_type;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_instr  = r_out_instr;
  assign bus.out_pc     = r_out_pc;
  assign bus.out_imm    = r_out_imm;
  assign bus.out_type   = r_out_type;
  assign bus.out_ebreak = r_out_ebreak;
  assign bus.halted     = r_halted;
  assign bus.trap       = r_trap;
  assign bus.trap_pc    = r_trap_pc;

`ifdef IDU_SEQ_PERF_EN
  assign bus.perf_decoded = r_perf_decoded;
  assign bus.perf_stall   = r_perf_stall;
  assign bus.perf_type_cnt = {r_perf_type[5], r_perf_type[4], r_perf_type[3],
                              r_perf_type[2], r_perf_type[1], r_perf_type[0]};
`endif
endmodule

// File: tb/tb_idu_seq.sv
// tb/tb_idu_seq.sv - directed bench for idu_seq; acts as IFU, immediate generator and EXU
module tb_idu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  idu_seq_if #(.TYPE_W(3), .XLEN(32)) bus ();

  idu_seq #(.TYPE_W(3), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  function automatic logic [31:0] gen_imm(logic [31:0] i, logic [2:0] t);
    case (t)
      3'd0:    return {{20{i[31]}}, i[31:20]};
      3'd1:    return {i[31:12], 12'b0};
      3'd2:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd3:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd4:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  always_comb bus.ig_imm = gen_imm(bus.ig_instr, bus.ig_type);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  task automatic run_one(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [2:0] typ, input logic [31:0] imm);
    chk({tag, "_in_ready_pre"}, 32'(bus.in_ready), 32'd1);
    present(instr, pc);
    step();
    bus.in_valid = 1'b0;
    chk({tag, "_dec_ig_type"}, 32'(bus.ig_type), 32'(typ));
    chk({tag, "_dec_valid"}, 32'(bus.out_valid), 32'd0);
    step();
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_out_type"}, 32'(bus.out_type), 32'(typ));
    chk({tag, "_out_imm"}, bus.out_imm, imm);
    chk({tag, "_out_pc"}, bus.out_pc, pc);
    chk({tag, "_out_instr"}, bus.out_instr, instr);
    chk({tag, "_ig_type_out"}, 32'(bus.ig_type), 32'd5);
    step();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ig_type", 32'(bus.ig_type), 32'd5);
    chk("rst_trap", 32'(bus.trap), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    rst = 1'b0;

    run_one("addi", 32'hfff00093, 32'h8000_0000, 3'd0, 32'hffff_ffff);
    chk("addi_back_idle", 32'(bus.in_ready), 32'd1);
    chk("addi_valid_fall", 32'(bus.out_valid), 32'd0);

    run_one("lui", 32'h123450b7, 32'h8000_0004, 3'd1, 32'h1234_5000);
    run_one("sw",  32'hfe112e23, 32'h8000_0008, 3'd2, 32'hffff_fffc);
    run_one("beq", 32'hfe000ee3, 32'h8000_000c, 3'd3, 32'hffff_fffc);
    run_one("jal", 32'hff9ff06f, 32'h8000_0010, 3'd4, 32'hffff_fff8);

    // add with a 5-cycle EXU stall
    bus.out_ready = 1'b0;
    present(32'h002081b3, 32'h8000_0020);
    step();
    bus.in_valid = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_instr", bus.out_instr, 32'h002081b3);
      chk("stall_imm", bus.out_imm, 32'h0);
      chk("stall_type", 32'(bus.out_type), 32'd5);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
`ifdef IDU_SEQ_PERF_EN
    chk("perf_stall", bus.perf_stall, 32'd5);
    chk("perf_decoded_pre", bus.perf_decoded, 32'd5);
`endif
    bus.out_ready = 1'b1;
    step();
    chk("stall_release_valid", 32'(bus.out_valid), 32'd0);
    chk("stall_release_ready", 32'(bus.in_ready), 32'd1);
`ifdef IDU_SEQ_PERF_EN
    chk("perf_decoded", bus.perf_decoded, 32'd6);
    chk("perf_type_r", bus.perf_type_cnt[191:160], 32'd1);
    chk("perf_type_i", bus.perf_type_cnt[31:0], 32'd1);
`endif

    // reset while holding a bundle in OUT
    bus.out_ready = 1'b0;
    present(32'h123450b7, 32'h8000_0030);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("preRst_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_instr", bus.out_instr, 32'h0);
    chk("midrst_pc", bus.out_pc, 32'h0);
    chk("midrst_imm", bus.out_imm, 32'h0);
    chk("midrst_type", 32'(bus.out_type), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_ig_type", 32'(bus.ig_type), 32'd5);
`ifdef IDU_SEQ_PERF_EN
    chk("midrst_perf", bus.perf_decoded, 32'd0);
`endif
    run_one("post_rst", 32'hfff00093, 32'h8000_0040, 3'd0, 32'hffff_ffff);

    // illegal opcode traps and stays trapped
    present(32'h0000007f, 32'h8000_0010);
    step();
    bus.in_valid = 1'b0;
    chk("trap_flag", 32'(bus.trap), 32'd1);
    chk("trap_pc", bus.trap_pc, 32'h8000_0010);
    chk("trap_in_ready", 32'(bus.in_ready), 32'd0);
    present(32'hfff00093, 32'h8000_0014);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("trap_valid", 32'(bus.out_valid), 32'd0);
      chk("trap_ig_type", 32'(bus.ig_type), 32'd5);
      chk("trap_sticky", 32'(bus.trap), 32'd1);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("trap_cleared", 32'(bus.trap), 32'd0);

    // ebreak halts after handoff
    run_one("ebreak", 32'h00100073, 32'h8000_0050, 3'd0, 32'h0000_0001);
    chk("halted", 32'(bus.halted), 32'd1);
    chk("halt_in_ready", 32'(bus.in_ready), 32'd0);
    chk("halt_valid", 32'(bus.out_valid), 32'd0);
    chk("halt_ebreak_flag", 32'(bus.out_ebreak), 32'd1);
    present(32'hfff00093, 32'h8000_0054);
    step();
    step();
    bus.in_valid = 1'b0;
    chk("halt_sticky", 32'(bus.halted), 32'd1);
    chk("halt_ignore_valid", 32'(bus.out_valid), 32'd0);
    chk("halt_ignore_ready", 32'(bus.in_ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
